// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam int unsigned DEFAULT_QUEUE_DEPTH  = 2;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        pred_taken;
   } fetch_entry_t;

   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction queue between fetch and decode; clear overrides push.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = DEFAULT_QUEUE_DEPTH,
   parameter type         entry_t = fetch_entry_t,
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W  = PTR_W + 1
)(
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_push,
   input  entry_t           i_entry,
   input  logic             i_pop,
   output entry_t           o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_empty   = (r_count == CNT_ZERO);
   assign o_full    = (r_count == CNT_FULL);
   assign o_count   = r_count;
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   // An empty queue presents an all-zero head so decode never sees stale words.
   assign o_head    = o_empty ? entry_t'({$bits(entry_t){1'b0}}) : r_mem[r_rd_ptr];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= CNT_ZERO;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= entry_t'({$bits(entry_t){1'b0}});
         end
      end else if (i_clear) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= CNT_ZERO;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: PC generation, single-outstanding imem requests, decode queue.
// FETCH_PREDICT_EN enables static branch prediction redirects.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned QUEUE_DEPTH  = DEFAULT_QUEUE_DEPTH
)(
   input  logic        clk,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] bp_instr_o,
   output logic [31:0] bp_pc_o,
   input  logic        bp_taken_i,
   input  logic [31:0] bp_target_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        pred_taken_o,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i
);

   localparam int unsigned     CNT_W     = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(QUEUE_DEPTH);

   fetch_state_t     r_state;
   fetch_state_t     w_state_nxt;
   logic [31:0]      r_fetch_pc;
   logic [31:0]      w_fetch_pc_nxt;
   logic [31:0]      r_req_pc;
   logic [31:0]      w_req_pc_nxt;
   logic             r_req;
   logic             w_req_nxt;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_clear;
   logic             w_taken;
   logic [31:0]      w_target;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_empty;
   logic             w_fifo_full_unused;
   fetch_entry_t     w_push_entry;
   fetch_entry_t     w_head;

`ifdef FETCH_PREDICT_EN
   assign w_taken    = bp_taken_i;
   assign w_target   = bp_target_i;
   assign bp_instr_o = imem_rdata_i;
   assign bp_pc_o    = r_req_pc;
`else
   logic w_unused_bp;
   assign w_taken     = 1'b0;
   assign w_target    = 32'h0000_0000;
   assign bp_instr_o  = 32'h0000_0000;
   assign bp_pc_o     = 32'h0000_0000;
   assign w_unused_bp = ^{bp_taken_i, bp_target_i};
`endif

   assign imem_req_o    = r_req;
   assign imem_addr_o   = r_fetch_pc;
   assign w_accept      = r_req && imem_gnt_i;
   assign w_pop         = !w_empty && instr_ready_i;
   assign w_push_entry  = '{instr: imem_rdata_i, pc: r_req_pc, pred_taken: w_taken};
   assign instr_valid_o = !w_empty;
   assign instr_o       = w_head.instr;
   assign pc_o          = w_head.pc;
   assign pred_taken_o  = w_head.pred_taken;

   // Next-state, next-PC and push decision; flush overrides everything.
   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_req_pc_nxt   = r_req_pc;
      w_push         = 1'b0;
      w_clear        = 1'b0;
      if (flush_i) begin
         w_clear        = 1'b1;
         w_fetch_pc_nxt = flush_pc_i;
         // A grant in this cycle or an unanswered request must have its response swallowed.
         if (w_accept || ((r_state != REQ) && !imem_valid_i)) begin
            w_state_nxt = DRAIN;
         end else begin
            w_state_nxt = REQ;
         end
      end else begin
         case (r_state)
            REQ: begin
               if (w_accept) begin
                  w_req_pc_nxt = r_fetch_pc;
                  w_state_nxt  = WAIT;
               end else begin
                  w_state_nxt  = REQ;
               end
            end
            WAIT: begin
               if (imem_valid_i) begin
                  w_push         = 1'b1;
                  w_fetch_pc_nxt = w_taken ? w_target : seq_pc(r_req_pc);
                  w_state_nxt    = REQ;
               end else begin
                  w_state_nxt    = WAIT;
               end
            end
            DRAIN: begin
               if (imem_valid_i) begin
                  w_state_nxt = REQ;
               end else begin
                  w_state_nxt = DRAIN;
               end
            end
            default: w_state_nxt = REQ;
         endcase
      end
   end

   // Queue occupancy after this edge decides whether a request may be raised.
   always_comb begin
      w_count_nxt = w_count;
      if (w_clear) begin
         w_count_nxt = CNT_ZERO;
      end else if (w_push && !w_pop) begin
         w_count_nxt = w_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
         w_count_nxt = w_count - CNT_ONE;
      end else begin
         w_count_nxt = w_count;
      end
      w_req_nxt = (w_state_nxt == REQ) && (w_count_nxt < CNT_CAP);
   end

   // Fetch FSM with registered request outputs.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_state    <= REQ;
         r_fetch_pc <= RESET_VECTOR;
         r_req_pc   <= 32'h0000_0000;
         r_req      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_req_pc   <= w_req_pc_nxt;
         r_req      <= w_req_nxt;
      end
   end

   fetch_fifo #(
      .DEPTH   (QUEUE_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk     (clk),
      .i_rst   (rst_i),
      .i_clear (w_clear),
      .i_push  (w_push),
      .i_entry (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_fifo_full_unused),
      .o_empty (w_empty)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table plus flush/backpressure sequences.
module tb_instruction_fetch;

   localparam logic [31:0] RV  = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] BEQ = 32'hFE00_08E3;
`ifdef FETCH_PREDICT_EN
   localparam logic PRED_EN = 1'b1;
`else
   localparam logic PRED_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_valid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] bp_instr_o;
   logic [31:0] bp_pc_o;
   logic        bp_taken_i;
   logic [31:0] bp_target_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        pred_taken_o;
   logic        flush_i;
   logic [31:0] flush_pc_i;

   instruction_fetch #(.RESET_VECTOR(RV), .QUEUE_DEPTH(2)) dut (
      .clk           (clk),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_valid_i  (imem_valid_i),
      .imem_rdata_i  (imem_rdata_i),
      .bp_instr_o    (bp_instr_o),
      .bp_pc_o       (bp_pc_o),
      .bp_taken_i    (bp_taken_i),
      .bp_target_i   (bp_target_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .pred_taken_o  (pred_taken_o),
      .flush_i       (flush_i),
      .flush_pc_i    (flush_pc_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        gnt;
      logic        valid;
      logic [31:0] rdata;
      logic        taken;
      logic [31:0] target;
      logic        ready;
      logic        flush;
      logic [31:0] fpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic        e_pred;
   } vec_t;

   vec_t vecs [17];
   int   total;
   int   bad;
   logic [31:0] x1;
   logic [31:0] n1;

   function automatic vec_t mk(
      input logic g, input logic v, input logic [31:0] rd, input logic tk, input logic [31:0] tg,
      input logic rdy, input logic fl, input logic [31:0] fp,
      input logic er, input logic [31:0] ea, input logic eiv, input logic [31:0] ei,
      input logic [31:0] ep, input logic epr);
      vec_t r;
      r.gnt = g; r.valid = v; r.rdata = rd; r.taken = tk; r.target = tg;
      r.ready = rdy; r.flush = fl; r.fpc = fp;
      r.e_req = er; r.e_addr = ea; r.e_iv = eiv; r.e_instr = ei; r.e_pc = ep; r.e_pred = epr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drv(input logic g, input logic v, input logic [31:0] rd, input logic tk,
                      input logic [31:0] tg, input logic rdy, input logic fl, input logic [31:0] fp);
      imem_gnt_i = g; imem_valid_i = v; imem_rdata_i = rd; bp_taken_i = tk; bp_target_i = tg;
      instr_ready_i = rdy; flush_i = fl; flush_pc_i = fp;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      x1 = PRED_EN ? 32'h0000_01F0 : 32'h0000_0204;
      n1 = PRED_EN ? 32'h0000_03F0 : 32'h0000_0304;

      //          g  v  rdata  tk target        rdy fl fpc            er ea           iv instr pc            pred
      vecs[0]  = mk(0, 0, 0,   0, 0,            1,  0, 0,             0, 0,           0, 0,   0,            0);
      vecs[1]  = mk(1, 0, 0,   0, 0,            1,  0, 0,             1, 32'h100,     0, 0,   0,            0);
      vecs[2]  = mk(0, 1, NOP, 0, 0,            1,  0, 0,             0, 0,           0, 0,   0,            0);
      vecs[3]  = mk(1, 0, 0,   0, 0,            1,  0, 0,             1, 32'h104,     1, NOP, 32'h100,      0);
      vecs[4]  = mk(0, 1, NOP, 0, 0,            1,  0, 0,             0, 0,           0, 0,   0,            0);
      vecs[5]  = mk(1, 0, 0,   0, 0,            1,  0, 0,             1, 32'h108,     1, NOP, 32'h104,      0);
      vecs[6]  = mk(0, 1, NOP, 0, 0,            1,  0, 0,             0, 0,           0, 0,   0,            0);
      vecs[7]  = mk(0, 0, 0,   0, 0,            1,  0, 0,             1, 32'h10C,     1, NOP, 32'h108,      0);
      vecs[8]  = mk(1, 0, 0,   0, 0,            1,  0, 0,             1, 32'h10C,     0, 0,   0,            0);
      vecs[9]  = mk(0, 0, 0,   0, 0,            1,  0, 0,             0, 0,           0, 0,   0,            0);
      vecs[10] = mk(0, 1, NOP, 0, 0,            1,  0, 0,             0, 0,           0, 0,   0,            0);
      vecs[11] = mk(0, 0, 0,   0, 0,            0,  1, 32'h200,       1, 32'h110,     1, NOP, 32'h10C,      0);
      vecs[12] = mk(1, 0, 0,   0, 0,            1,  0, 0,             1, 32'h200,     0, 0,   0,            0);
      vecs[13] = mk(0, 1, BEQ, 1, 32'h1F0,      1,  0, 0,             0, 0,           0, 0,   0,            0);
      vecs[14] = mk(1, 0, 0,   0, 0,            1,  0, 0,             1, x1,          1, BEQ, 32'h200,      PRED_EN);
      vecs[15] = mk(0, 1, NOP, 0, 0,            1,  0, 0,             0, 0,           0, 0,   0,            0);
      vecs[16] = mk(0, 0, 0,   0, 0,            1,  0, 0,             1, x1 + 32'd4,  1, NOP, x1,           0);

      rst_i = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst_req", imem_req_o, 0);
      chk("rst_valid", instr_valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_pred", pred_taken_o, 0);
      rst_i = 1'b0;

      for (int i = 0; i < 17; i++) begin
         drv(vecs[i].gnt, vecs[i].valid, vecs[i].rdata, vecs[i].taken, vecs[i].target,
             vecs[i].ready, vecs[i].flush, vecs[i].fpc);
         chk($sformatf("v%0d_req", i), imem_req_o, vecs[i].e_req);
         if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].e_addr);
         chk($sformatf("v%0d_ivalid", i), instr_valid_o, vecs[i].e_iv);
         if (vecs[i].e_iv) begin
            chk($sformatf("v%0d_instr", i), instr_o, vecs[i].e_instr);
            chk($sformatf("v%0d_pc", i), pc_o, vecs[i].e_pc);
            chk($sformatf("v%0d_pred", i), pred_taken_o, vecs[i].e_pred);
         end
         tick();
      end

      // Taken branch at 0x300, then fill the queue with decode stalled.
      drv(0, 0, 0, 0, 0, 0, 1, 32'h300); tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      chk("br_req", imem_req_o, 1); chk("br_addr", imem_addr_o, 32'h300); tick();
      drv(0, 1, 32'h0000_0063, 1, 32'h3F0, 0, 0, 0);
      chk("bp_pc", bp_pc_o, PRED_EN ? 32'h300 : 32'h0);
      chk("bp_instr", bp_instr_o, PRED_EN ? 32'h63 : 32'h0); tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      chk("br_next_addr", imem_addr_o, n1); chk("br_head_pc", pc_o, 32'h300);
      chk("br_head_pred", pred_taken_o, PRED_EN); tick();
      drv(0, 1, NOP, 0, 0, 0, 0, 0); tick();
      for (int k = 0; k < 3; k++) begin
         drv(1, 0, 0, 0, 0, 0, 0, 0);
         chk("full_req", imem_req_o, 0); chk("full_head", pc_o, 32'h300); tick();
      end
      drv(1, 0, 0, 0, 0, 1, 0, 0);
      chk("pop_cycle_req", imem_req_o, 0); tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      chk("one_req", imem_req_o, 1); chk("one_addr", imem_addr_o, n1 + 32'd4);
      chk("one_head", pc_o, n1); tick();
      drv(0, 1, NOP, 0, 0, 0, 0, 0);
      chk("one_wait_req", imem_req_o, 0); tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      chk("one_only_req", imem_req_o, 0); tick();

      // Flush while waiting, with a late response that must be dropped.
      drv(0, 0, 0, 0, 0, 1, 0, 0);
      chk("fw_head", pc_o, n1); tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      chk("fw_req_addr", imem_addr_o, n1 + 32'd8); tick();
      drv(0, 0, 0, 0, 0, 0, 1, 32'h400);
      chk("fw_pre_valid", instr_valid_o, 1); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("fw_empty", instr_valid_o, 0); chk("fw_drain_req", imem_req_o, 0); tick();
      drv(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      chk("fw_late_req", imem_req_o, 0); tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      chk("fw_restart_req", imem_req_o, 1); chk("fw_restart_addr", imem_addr_o, 32'h400);
      chk("fw_no_push", instr_valid_o, 0); tick();

      // Flush coinciding with the response: dropped, no drain.
      drv(0, 1, NOP, 0, 0, 0, 1, 32'h600); tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      chk("fv_req", imem_req_o, 1); chk("fv_addr", imem_addr_o, 32'h600);
      chk("fv_empty", instr_valid_o, 0); tick();
      drv(0, 1, 32'h0000_0093, 0, 0, 0, 0, 0); tick();

      // Flush coinciding with a grant: that response must be drained.
      drv(1, 0, 0, 0, 0, 1, 1, 32'h700);
      chk("fv_head_valid", instr_valid_o, 1); chk("fv_head_pc", pc_o, 32'h600);
      chk("fv_head_instr", instr_o, 32'h93); chk("fg_pre_req", imem_req_o, 1); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("fg_drain_req", imem_req_o, 0); chk("fg_empty", instr_valid_o, 0); tick();
      drv(0, 1, NOP, 0, 0, 0, 0, 0);
      chk("fg_drain2_req", imem_req_o, 0); tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      chk("fg_req", imem_req_o, 1); chk("fg_addr", imem_addr_o, 32'h700);
      chk("fg_no_push", instr_valid_o, 0); tick();

      // Reset with a request outstanding; the stale response is ignored.
      rst_i = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("mrst_req", imem_req_o, 0); chk("mrst_valid", instr_valid_o, 0);
      rst_i = 1'b0;
      drv(0, 1, NOP, 0, 0, 0, 0, 0);
      chk("mrst_stale_req", imem_req_o, 0); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("mrst_restart_req", imem_req_o, 1); chk("mrst_restart_addr", imem_addr_o, RV);
      chk("mrst_no_push", instr_valid_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage front end: generates the program counter, issues one instruction-memory request at a time, and buffers returned instruction words in a small FIFO for decode. Each returned word is offered combinationally to the static branch predictor. A predicted-taken branch redirects the next fetch to the predicted target. An execute-stage flush discards all in-flight and buffered instructions and restarts fetch at the corrected PC.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC of first fetch after reset
- QUEUE_DEPTH, 2, instruction FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  32  request address (word aligned)
- imem_gnt_i  in  1  request accepted this cycle
- imem_valid_i  in  1  read data valid
- imem_rdata_i  in  32  instruction word
- bp_instr_o  out  32  = imem_rdata_i (to predictor)
- bp_pc_o  out  32  PC of the word on imem_rdata_i
- bp_taken_i  in  1  predictor: branch predicted taken
- bp_target_i  in  32  predictor: target PC
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  decode accepts head
- instr_o  out  32  head instruction
- pc_o  out  32  head PC
- pred_taken_o  out  1  head was predicted taken
- flush_i  in  1  redirect from execute
- flush_pc_i  in  32  restart PC

## Operation
- FSM states: REQ, WAIT, DRAIN.
- REQ:
  - imem_req_o=1 only when (fifo_count + 0) < QUEUE_DEPTH; imem_addr_o=fetch_pc.
  - On gnt: latch req_pc=fetch_pc, → WAIT.
- WAIT: imem_req_o=0. On imem_valid_i:
  - Push {imem_rdata_i, req_pc, bp_taken_i} into FIFO.
  - fetch_pc = bp_taken_i ? bp_target_i : req_pc+4 (32-bit wrap).
  - → REQ.
- DRAIN: discard the single outstanding response. On imem_valid_i → REQ. No push.
- Flush (highest priority, any state):
  - FIFO cleared, fetch_pc=flush_pc_i.
  - State → DRAIN if a request is outstanding and its response has not arrived in the flush cycle, else → REQ.
  - A response arriving in the flush cycle is dropped.
  - A request granted in the flush cycle counts as outstanding (→ DRAIN).
- bp_pc_o=req_pc. Predictor inputs are sampled only in WAIT with imem_valid_i.
- FIFO pop when instr_valid_o && instr_ready_i. Push and pop in the same cycle are allowed at full (count unchanged) only if a pop occurs; the issue rule guarantees no push into a full FIFO.
- Addresses are not checked for alignment. Targets are used as given.

## Timing
- Reset values:
  - imem_req_o=0 in the reset cycle; REQ state with fetch_pc=RESET_VECTOR.
  - FIFO empty: instr_valid_o=0, instr_o=0, pc_o=0, pred_taken_o=0.
- First request asserted the cycle after rst_i deasserts.
- Single outstanding request. Response earliest one cycle after gnt.
- Best-case throughput: one instruction per 2 cycles (REQ+WAIT) with zero-wait memory.
- Response to instr_valid_o: 1 cycle (registered FIFO).
- Predicted target appears on imem_addr_o in the cycle after the response.
- instr_valid_o drops the cycle after flush_i. flush_pc_i appears on imem_addr_o in the next REQ cycle.
- imem_req_o is held with a stable address until gnt; it is withdrawn only by flush or rst_i.
- rst_i mid-transaction: outstanding response is ignored. The memory is expected to be reset with the same rst_i.

## Configuration
- FETCH_PREDICT_EN defined: behaviour as above.
- FETCH_PREDICT_EN undefined:
  - bp_taken_i/bp_target_i are ignored; next PC is always req_pc+4.
  - pred_taken_o is tied to 0.
  - bp_instr_o/bp_pc_o are driven to 0.

## Structure
- Shared package `fetch_pkg`:
  - fetch_state_t enum (REQ, WAIT, DRAIN).
  - fetch_entry_t struct {instr[31:0], pc[31:0], pred_taken}.
  - RESET_VECTOR default constant.
- Sub-module `fetch_fifo`: parameterised by depth and fetch_entry_t. Push, pop, clear, count, full/empty; clear has priority over push.

## Test plan
- Reset, RESET_VECTOR=0x100, zero-wait memory returning NOPs, ready=1 → addresses 0x100, 0x104, 0x108 on successive REQ cycles; pc_o follows 1 cycle after each response.
- Response at PC 0x200 = backward BEQ, predictor taken, target 0x1F0 → next imem_addr_o=0x1F0, head pred_taken_o=1 with pc_o=0x200.
- instr_ready_i=0, QUEUE_DEPTH=2 → after two pushes imem_req_o=0. Ready=1 for one cycle → exactly one new request issued.
- flush_i with flush_pc_i=0x400 while in WAIT → FIFO empty next cycle; late response dropped; next address 0x400.
- flush_i in the same cycle as imem_valid_i → word not pushed, no DRAIN, next request to flush_pc_i.
- Macro undefined, taken branch at 0x300 → next address 0x304, pred_taken_o=0.
